cache_flush_ctrl: RTL

Sequencer that owns the single data-memory port below the direct-mapped data cache. When idle it forwards the cache controller's miss/write-back traffic unchanged. On a flush request it stalls the CPU, walks all cache lines, writes every valid+dirty line back to data memory at `{tag, index}`, clears its dirty bit, and reports completion. It replaces testbench-level backdoor flushing with a real hardware flush path.

---
 rtl/cache_flush_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/cache_flush_ctrl.sv
// Flush sequencer that owns the data-memory port below the direct-mapped cache.
// Optional `CACHE_FLUSH_STATS_EN adds flush_count_o (lines written by the last flush).
module cache_flush_ctrl #(
    parameter int LINES  = 32,
    parameter int IDX_W  = 5,
    parameter int TAG_W  = 22,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 27
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              flush_req_i,
    output logic              flush_busy_o,
    output logic              flush_done_o,
    output logic              stall_o,
    output logic [IDX_W-1:0]  line_idx_o,
    input  logic [TAG_W-1:0]  line_tag_i,
    input  logic [LINE_W-1:0] line_data_i,
    input  logic              line_valid_i,
    input  logic              line_dirty_i,
    output logic              line_clean_o,
    input  logic              cc_ren_i,
    input  logic              cc_wen_i,
    input  logic [ADDR_W-1:0] cc_addr_i,
    input  logic [LINE_W-1:0] cc_wdata_i,
    output logic [LINE_W-1:0] cc_rdata_o,
    output logic              cc_ready_o,
    output logic              MEM_ren,
    output logic              MEM_wen,
    output logic [ADDR_W-1:0] MEM_addr,
    output logic [LINE_W-1:0] MEM_wdata,
    input  logic [LINE_W-1:0] MEM_rdata,
    input  logic              MEM_ready
`ifdef CACHE_FLUSH_STATS_EN
    ,
    output logic [IDX_W:0]    flush_count_o
`endif
);

    // state   | meaning
    // S_IDLE  | cc traffic passes straight through to memory
    // S_DRAIN | flush accepted, waiting for the in-flight cc transaction
    // S_SCAN  | examine line idx; dirty+valid lines go to S_WRITE
    // S_WRITE | write latched line back, clear its dirty bit on ready
    // S_DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_SCAN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic                flush_req_q;
    logic                busy_q;
    logic                done_q;
    logic [ADDR_W-1:0]   wr_addr;
    logic [LINE_W-1:0]   wr_data;
    logic                flush_rise;
    logic                last_line;

    assign flush_rise = flush_req_i & ~flush_req_q;
    assign last_line  = (idx == IDX_W'(LINES - 1));

`ifdef CACHE_FLUSH_STATS_EN
    logic [IDX_W:0] count_q;
    assign flush_count_o = count_q;
`endif

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state       <= S_IDLE;
            idx         <= '0;
            flush_req_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
`ifdef CACHE_FLUSH_STATS_EN
            count_q     <= '0;
`endif
        end else begin
            flush_req_q <= flush_req_i;
            case (state)
                S_IDLE: begin
                    if (flush_rise) begin
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= (cc_ren_i | cc_wen_i) ? S_DRAIN : S_SCAN;
`ifdef CACHE_FLUSH_STATS_EN
                        count_q <= '0;
`endif
                    end
                end
                S_DRAIN: begin
                    if (MEM_ready) begin
                        idx   <= '0;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (line_valid_i & line_dirty_i) begin
                        wr_addr <= {line_tag_i, idx};
                        wr_data <= line_data_i;
                        state   <= S_WRITE;
                    end else if (last_line) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (MEM_ready) begin
`ifdef CACHE_FLUSH_STATS_EN
                        count_q <= count_q + 1'b1;
`endif
                        if (last_line) begin
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign flush_busy_o = busy_q;
    assign stall_o      = busy_q;
    assign flush_done_o = done_q;
    assign line_idx_o   = idx;
    assign cc_rdata_o   = MEM_rdata;

    // Memory port mux; the dirty-bit clear must coincide with the accepting ready.
    always_comb begin
        MEM_ren      = 1'b0;
        MEM_wen      = 1'b0;
        MEM_addr     = '0;
        MEM_wdata    = '0;
        cc_ready_o   = 1'b0;
        line_clean_o = 1'b0;
        case (state)
            S_IDLE, S_DRAIN: begin
                MEM_ren    = cc_ren_i;
                MEM_wen    = cc_wen_i;
                MEM_addr   = cc_addr_i;
                MEM_wdata  = cc_wdata_i;
                cc_ready_o = MEM_ready;
            end
            S_WRITE: begin
                MEM_wen      = 1'b1;
                MEM_addr     = wr_addr;
                MEM_wdata    = wr_data;
                line_clean_o = MEM_ready;
            end
            default: begin
                MEM_ren = 1'b0;
            end
        endcase
    end

endmodule
